// File: rtl/scs8hd_a2111o_pkg.sv
// scs8hd_a2111o_pkg
// Shared definitions for the pipelined a2111o macro.
//   A2111O / A2111OI : values of the INVERT parameter (OR vs NOR output)
//   params_ok()      : legal-range check applied to the top-level parameters
//   a2111o_f()       : single-channel a2111o(i) bit operation; the top applies
//                      it across any WIDTH by iterating over channels
package scs8hd_a2111o_pkg;

    localparam int A2111O     = 0;
    localparam int A2111OI    = 1;
    localparam int MAX_WIDTH  = 64;
    localparam int MAX_STAGES = 4;

    function automatic bit params_ok(input int width, input int stages,
                                     input int invert, input int cnt_w);
        return (width >= 1) && (width <= MAX_WIDTH) &&
               (stages >= 1) && (stages <= MAX_STAGES) &&
               ((invert == A2111O) || (invert == A2111OI)) &&
               (cnt_w >= 1);
    endfunction

    function automatic logic a2111o_f(input logic a1, input logic a2,
                                      input logic b1, input logic c1,
                                      input logic d1, input logic inv);
        logic f;
        f = (a1 & a2) | b1 | c1 | d1;
        return inv ? ~f : f;
    endfunction

endpackage

// File: rtl/scs8hd_a2111o_stage.sv
// scs8hd_a2111o_stage
// One valid/data register slice of the a2111o pipeline.
//   CLK, RESET : clock and synchronous active-high reset
//   adv_i      : slice loads from upstream this cycle (otherwise holds)
//   vld_i/d_i  : upstream valid and data
//   vld_o/d_o  : registered valid and data of this slice
module scs8hd_a2111o_stage #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             adv_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] d_o
);

    logic             vld_q;
    logic [WIDTH-1:0] d_q;

    // Data is cleared on reset as well so X reads zero after RESET.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld_q <= 1'b0;
            d_q   <= '0;
        end else if (adv_i) begin
            vld_q <= vld_i;
            d_q   <= d_i;
        end
    end

    assign vld_o = vld_q;
    assign d_o   = d_q;

endmodule

// File: rtl/scs8hd_a2111o_pipe.sv
// scs8hd_a2111o_pipe
// WIDTH-channel X = (A1&A2)|B1|C1|D1 (NOR when INVERT=A2111OI), registered
// through a STAGES-deep valid/ready pipeline, plus a saturating hit counter.
//   CLK, RESET          : clock, synchronous active-high reset
//   A1,A2,B1,C1,D1      : per-channel operands
//   in_valid / in_ready : input handshake (in_ready combinational from out_ready)
//   X / out_valid       : final-stage result and its valid
//   out_ready           : consumer accepts X this cycle
//   hits / clr_hits     : count of delivered non-zero results, synchronous clear
module scs8hd_a2111o_pipe
    import scs8hd_a2111o_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int INVERT = A2111O,
    parameter int CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    input  logic [WIDTH-1:0] B1,
    input  logic [WIDTH-1:0] C1,
    input  logic [WIDTH-1:0] D1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] X,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] hits,
    input  logic             clr_hits
);

    if (!params_ok(WIDTH, STAGES, INVERT, CNT_W)) begin : g_param_err
        $error("scs8hd_a2111o_pipe: parameter out of range");
    end

    localparam logic INV = (INVERT == A2111OI);

    logic [WIDTH-1:0]  f_p0;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] vld;
    logic [WIDTH-1:0]  dat [STAGES];
    logic [CNT_W-1:0]  hits_q;
    logic [CNT_W-1:0]  hits_d;
    logic              deliver;

    // Combinational function ahead of stage 0.
    always_comb begin
        f_p0 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            f_p0[i] = a2111o_f(A1[i], A2[i], B1[i], C1[i], D1[i], INV);
        end
    end

    // Advance chain: a stage loads when it is empty or its downstream moves.
    // Walked from the output back so each stage sees the one after it.
    always_comb begin
        logic a;
        a   = out_ready;
        adv = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            a      = ~vld[k] | a;
            adv[k] = a;
        end
    end

    // Stage boundaries: stage 0 takes the operands, later stages the previous slice.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             vld_up;
        logic [WIDTH-1:0] dat_up;
        if (k == 0) begin : g_head
            assign vld_up = in_valid;
            assign dat_up = f_p0;
        end else begin : g_body
            assign vld_up = vld[k-1];
            assign dat_up = dat[k-1];
        end
        scs8hd_a2111o_stage #(.WIDTH(WIDTH)) u_stage (
            .CLK   (CLK),
            .RESET (RESET),
            .adv_i (adv[k]),
            .vld_i (vld_up),
            .d_i   (dat_up),
            .vld_o (vld[k]),
            .d_o   (dat[k])
        );
    end

    assign in_ready  = adv[0];
    assign X         = dat[STAGES-1];
    assign out_valid = vld[STAGES-1];

    // Hit counter: clear wins over a same-cycle delivery; holds at all-ones.
    assign deliver = out_valid & out_ready & (|X);

    always_comb begin
        hits_d = hits_q;
        if (clr_hits) begin
            hits_d = '0;
        end else if (deliver && (hits_q != {CNT_W{1'b1}})) begin
            hits_d = hits_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hits_q <= '0;
        end else begin
            hits_q <= hits_d;
        end
    end

    assign hits = hits_q;

endmodule

// File: tb/tb_scs8hd_a2111o_pipe.sv
// Bench: two configurations driven from the same inputs
//   dut0: STAGES=3, INVERT=0, CNT_W=4   dut1: STAGES=2, INVERT=1, CNT_W=16
// Each is compared every cycle against a transaction-level model: a queue of
// accepted results, an occupancy rule for in_ready, and an earliest-arrival
// rule for when the oldest result may be presented.
module tb_scs8hd_a2111o_pipe;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [W-1:0] A1, A2, B1, C1, D1;
    logic         in_valid, out_ready, clr_hits;
    logic         in_ready0, in_ready1, out_valid0, out_valid1;
    logic [W-1:0] X0, X1;
    logic [3:0]   hits0;
    logic [15:0]  hits1;

    always #5 CLK = ~CLK;

    scs8hd_a2111o_pipe #(.WIDTH(W), .STAGES(3), .INVERT(0), .CNT_W(4)) dut0 (
        .CLK(CLK), .RESET(RESET), .A1(A1), .A2(A2), .B1(B1), .C1(C1), .D1(D1),
        .in_valid(in_valid), .in_ready(in_ready0), .X(X0), .out_valid(out_valid0),
        .out_ready(out_ready), .hits(hits0), .clr_hits(clr_hits));

    scs8hd_a2111o_pipe #(.WIDTH(W), .STAGES(2), .INVERT(1), .CNT_W(16)) dut1 (
        .CLK(CLK), .RESET(RESET), .A1(A1), .A2(A2), .B1(B1), .C1(C1), .D1(D1),
        .in_valid(in_valid), .in_ready(in_ready1), .X(X1), .out_valid(out_valid1),
        .out_ready(out_ready), .hits(hits1), .clr_hits(clr_hits));

    typedef struct packed {
        logic [W-1:0] data;
        int           acc;
    } item_t;

    item_t qm [2][$];
    int    head_ok [2];
    int    hits_m  [2];
    int    cyc;
    int    n_checks;
    int    n_errors;

    function automatic int stg_of(input int id);
        return (id == 0) ? 3 : 2;
    endfunction

    function automatic int hmax_of(input int id);
        return (id == 0) ? 15 : 65535;
    endfunction

    // Channel i is high when A1&A2 both set or any of B1/C1/D1 set; NOR flips it.
    function automatic logic [W-1:0] ref_x(input bit invert);
        logic [W-1:0] r;
        bit any;
        for (int i = 0; i < W; i++) begin
            any  = (A1[i] && A2[i]) || B1[i] || C1[i] || D1[i];
            r[i] = invert ? !any : any;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_ops(input logic [W-1:0] a1, input logic [W-1:0] a2,
                           input logic [W-1:0] b1, input logic [W-1:0] c1,
                           input logic [W-1:0] d1);
        A1 = a1; A2 = a2; B1 = b1; C1 = c1; D1 = d1;
    endtask

    // One clock cycle: called just after a falling edge with inputs set.
    task automatic tick();
        bit           acc [2];
        bit           del [2];
        logic [W-1:0] xd  [2];
        bit           eir, eov;
        int           first;
        #1;
        for (int id = 0; id < 2; id++) begin
            eir = (qm[id].size() < stg_of(id)) || out_ready;
            eov = 1'b0;
            if (qm[id].size() > 0) begin
                first = qm[id][0].acc + stg_of(id);
                if (head_ok[id] > first) first = head_ok[id];
                eov = (cyc >= first);
            end
            chk($sformatf("in_ready%0d", id), (id == 0) ? in_ready0 : in_ready1, eir);
            chk($sformatf("out_valid%0d", id), (id == 0) ? out_valid0 : out_valid1, eov);
            if (eov) chk($sformatf("x%0d", id), (id == 0) ? X0 : X1, qm[id][0].data);
            chk($sformatf("hits%0d", id), (id == 0) ? 64'(hits0) : 64'(hits1), hits_m[id]);
            acc[id] = in_valid && eir;
            del[id] = eov && out_ready;
            xd[id]  = ref_x(id == 1);
        end
        @(posedge CLK);
        for (int id = 0; id < 2; id++) begin
            if (RESET) begin
                qm[id].delete();
                hits_m[id]  = 0;
                head_ok[id] = 0;
            end else begin
                if (clr_hits) hits_m[id] = 0;
                else if (del[id] && (qm[id][0].data != 0) && (hits_m[id] < hmax_of(id)))
                    hits_m[id]++;
                if (del[id]) begin
                    void'(qm[id].pop_front());
                    head_ok[id] = cyc + 1;
                end
                if (acc[id]) qm[id].push_back('{data: xd[id], acc: cyc});
            end
        end
        cyc++;
        @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx;
        int  h0, h1;
        bit  will_acc;
        n_checks = 0; n_errors = 0; cyc = 0;
        for (int id = 0; id < 2; id++) begin
            hits_m[id] = 0; head_ok[id] = 0;
        end
        RESET = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_hits = 1'b0;
        set_ops('0, '0, '0, '0, '0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("rst_x0", X0, 0);
        chk("rst_x1", X1, 0);
        chk("rst_in_ready0", in_ready0, 1);

        // Function / inversion with the reference operands.
        set_ops(8'h0F, 8'h05, 8'h10, 8'h00, 8'h80);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        chk("fn_inv_vld", out_valid1, 1);
        chk("fn_inv_x", X1, 8'h6A);
        tick();
        #1;
        chk("fn_vld", out_valid0, 1);
        chk("fn_x", X0, 8'h95);
        tick();
        #1;
        chk("fn_hits0", hits0, 1);
        chk("fn_hits1", hits1, 1);
        repeat (2) tick();

        // All-zero operands: NOR gives all-ones and counts, OR gives zero.
        set_ops('0, '0, '0, '0, '0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        #1;
        chk("zero_hits0", hits0, 1);
        chk("zero_hits1", hits1, 2);

        // Reset with two items in flight.
        set_ops(8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
        in_valid = 1'b1;
        tick();
        set_ops(8'h00, 8'h00, 8'h3C, 8'h00, 8'h00);
        tick();
        RESET = 1'b1;
        repeat (3) tick();
        RESET = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mrst_x0", X0, 0);
        chk("mrst_x1", X1, 0);
        chk("mrst_vld0", out_valid0, 0);
        chk("mrst_rdy0", in_ready0, 1);
        chk("mrst_hits1", hits1, 0);
        repeat (5) tick();

        // Backpressure: five distinct items, stall after the first accept.
        idx = 0;
        for (int k = 0; k < 20; k++) begin
            out_ready = (k == 0) || (k >= 8);
            in_valid  = (idx < 5);
            set_ops('0, '0, 8'(8'h11 * (idx + 1)), '0, '0);
            if (k == 5) begin
                #1;
                chk("bp_full_rdy0", in_ready0, 0);
            end
            will_acc = in_valid && ((qm[0].size() < 3) || out_ready);
            tick();
            if (will_acc) idx++;
        end
        chk("bp_accepted", idx, 5);
        chk("bp_drained", qm[0].size() == 0, 1);

        // Saturation of the 4-bit counter.
        in_valid = 1'b0; out_ready = 1'b1;
        clr_hits = 1'b1;
        tick();
        clr_hits = 1'b0;
        set_ops('0, '0, 8'h01, '0, '0);
        in_valid = 1'b1;
        repeat (20) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        #1;
        chk("sat_hits0", hits0, 15);
        chk("sat_hits1", hits1, 20);

        // Clear coincident with a dut0 delivery.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        clr_hits = 1'b1;
        #1;
        chk("clr_coinc_vld0", out_valid0, 1);
        tick();
        clr_hits = 1'b0;
        #1;
        chk("clr_hits0", hits0, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        #1;
        chk("clr_after_hits0", hits0, 1);

        // Bubbles, with zero-valued results on alternate valid slots.
        h0 = hits_m[0]; h1 = hits_m[1];
        for (int k = 0; k < 8; k++) begin
            in_valid = (k % 2 == 0);
            if (k % 4 == 0) set_ops(8'hFF, 8'hFF, '0, '0, '0);
            else            set_ops('0, '0, '0, '0, '0);
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        #1;
        chk("bub_hits0", hits0, h0 + 2);
        chk("bub_hits1", hits1, h1 + 2);

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 70);
            clr_hits  = ($urandom_range(0, 99) < 3);
            RESET     = ($urandom_range(0, 199) == 0);
            set_ops(8'($urandom), 8'($urandom), 8'($urandom & $urandom),
                    8'($urandom & $urandom & $urandom), 8'($urandom & $urandom & $urandom));
            tick();
        end
        RESET = 1'b0; clr_hits = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
